// File: rtl/program_loader.sv
// UART program loader: streams a length header plus ROM words out on txd (8N1),
// and independently assembles 32-bit result words from bytes arriving on rxd.
module program_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 10
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  output logic              txd,
  input  logic              rxd,
  output logic              busy,
  output logic              done,
  output logic [31:0]       result_word,
  output logic              result_valid,
  output logic              rx_frame_err
);

  localparam int CW   = $clog2(CLKS_PER_BIT + 1);
  localparam int HALF = (CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

  // ---------------- transmit ----------------
  typedef enum logic [2:0] {IDLE, HDR, FETCH, WORD, DONE} tx_st_t;

  tx_st_t          st;
  logic [CW-1:0]   tcnt;
  logic [3:0]      tbit;   // 0 = start bit, 1..8 = data, 9 = stop
  logic [1:0]      tbyte;
  logic [31:0]     tsh;
  logic [ADDR_W:0] tleft;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st       <= IDLE;
      txd      <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      rom_addr <= '0;
      tcnt     <= '0;
      tbit     <= '0;
      tbyte    <= '0;
      tsh      <= '0;
      tleft    <= '0;
    end else begin
      case (st)
        IDLE, DONE: if (start) begin
          tleft <= word_count;
          tsh   <= 32'(word_count);
          txd   <= 1'b0;
          tcnt  <= '0;
          tbit  <= '0;
          tbyte <= '0;
          busy  <= 1'b1;
          done  <= 1'b0;
          st    <= HDR;
        end
        HDR, WORD: begin
          if (tcnt != BIT_LAST) begin
            tcnt <= tcnt + 1'b1;
          end else begin
            tcnt <= '0;
            if (tbit != 4'd9) begin
              tbit <= tbit + 1'b1;
              txd  <= (tbit == 4'd8) ? 1'b1 : tsh[tbit[2:0]];
            end else if (tbyte != 2'd3) begin
              // next byte follows the stop bit with no idle gap
              tbyte <= tbyte + 1'b1;
              tbit  <= '0;
              tsh   <= tsh >> 8;
              txd   <= 1'b0;
            end else if (st == HDR) begin
              if (tleft == '0) begin
                busy <= 1'b0;
                done <= 1'b1;
                st   <= DONE;
              end else begin
                rom_addr <= '0;
                st       <= FETCH;
              end
            end else begin
              rom_addr <= rom_addr + 1'b1;
              tleft    <= tleft - 1'b1;
              if (tleft == (ADDR_W+1)'(1)) begin
                busy <= 1'b0;
                done <= 1'b1;
                st   <= DONE;
              end else begin
                st <= FETCH;
              end
            end
          end
        end
        FETCH: begin
          tsh   <= rom_data;
          txd   <= 1'b0;
          tcnt  <= '0;
          tbit  <= '0;
          tbyte <= '0;
          st    <= WORD;
        end
        default: st <= IDLE;
      endcase
    end
  end

  // ---------------- receive ----------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_st_t;

  rx_st_t          rst;
  logic [1:0]      sync;
  logic            rx_prev;
  logic [CW-1:0]   rcnt;
  logic [2:0]      rbit;
  logic [7:0]      rsh;
  logic [1:0]      ridx;
  logic [2:0][7:0] racc;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync         <= 2'b11;
      rx_prev      <= 1'b1;
      rst          <= RX_IDLE;
      rcnt         <= '0;
      rbit         <= '0;
      rsh          <= '0;
      ridx         <= '0;
      racc         <= '0;
      result_word  <= '0;
      result_valid <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      sync         <= {sync[0], rxd};
      rx_prev      <= sync[1];
      result_valid <= 1'b0;
      rx_frame_err <= 1'b0;
      case (rst)
        // a falling edge needs a high sample first, so a stuck-low line never re-arms
        RX_IDLE: if (rx_prev && !sync[1]) begin
          rst  <= RX_START;
          rcnt <= '0;
        end
        RX_START: begin
          if (rcnt != HALF_LAST) begin
            rcnt <= rcnt + 1'b1;
          end else begin
            rcnt <= '0;
            rbit <= '0;
            rst  <= sync[1] ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          if (rcnt != BIT_LAST) begin
            rcnt <= rcnt + 1'b1;
          end else begin
            rcnt <= '0;
            rsh  <= {sync[1], rsh[7:1]};
            rbit <= rbit + 1'b1;
            if (rbit == 3'd7) rst <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (rcnt != BIT_LAST) begin
            rcnt <= rcnt + 1'b1;
          end else begin
            rcnt <= '0;
            rst  <= RX_IDLE;
            if (!sync[1]) begin
              rx_frame_err <= 1'b1;
            end else if (ridx == 2'd3) begin
              result_word  <= {rsh, racc[2], racc[1], racc[0]};
              result_valid <= 1'b1;
              ridx         <= '0;
            end else begin
              racc[ridx] <= rsh;
              ridx       <= ridx + 1'b1;
            end
          end
        end
        default: rst <= RX_IDLE;
      endcase
    end
  end

endmodule
